// File: rtl/maze_pkg.sv
// maze_pkg: maze geometry and loader types shared by the maze writer and the slave register file.
package maze_pkg;
  localparam int NUM_WORDS = 600;
  localparam int NUM_MAZES = 4;
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, VERIFY, DONE} ldr_state_t;
  typedef logic [31:0] maze_word_t;
endpackage

// File: rtl/maze_avl_writer.sv
// maze_avl_writer: copies one NUM_WORDS maze from ROM into the Avalon slave register file.
// Define MAZE_READBACK_EN to read each word back after writing it and flag mismatches on verify_err.
module maze_avl_writer
  import maze_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int ROM_ADDR_W = 12
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic [1:0]            maze_sel,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  maze_word_t            rom_data,
  output logic                  AVM_CS,
  output logic                  AVM_WRITE,
  output logic [ADDR_W-1:0]     AVM_ADDR,
  output logic [3:0]            AVM_BYTE_EN,
  output maze_word_t            AVM_WRITEDATA,
  input  logic                  AVM_WAITREQUEST,
`ifdef MAZE_READBACK_EN
  output logic                  AVM_READ,
  input  maze_word_t            AVM_READDATA,
  output logic                  verify_err,
`endif
  output logic                  busy,
  output logic                  maze_ready
);
  ldr_state_t        state_q, adv_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        sel_q;
  maze_word_t        wdata_q;
  logic              first_q, last, wr_ph, rd_ph;
`ifdef MAZE_READBACK_EN
  logic              rd_pend_q, err_q;
  assign rd_ph      = state_q == VERIFY && !rd_pend_q;
  assign AVM_READ   = rd_ph;
  assign verify_err = err_q;
`else
  assign rd_ph      = 1'b0;
`endif
  assign last          = idx_q == ADDR_W'(NUM_WORDS - 1);
  assign idx_d         = last ? '0 : idx_q + 1'b1;
  assign adv_d         = last ? DONE : FETCH;
  assign wr_ph         = state_q == WRITE;
  assign AVM_CS        = wr_ph | rd_ph;
  assign AVM_WRITE     = wr_ph;
  assign AVM_ADDR      = AVM_CS ? idx_q : '0;
  assign AVM_BYTE_EN   = {4{AVM_CS}};
  // ROM data arrives during the first WRITE cycle; later stall cycles replay the captured copy
  assign AVM_WRITEDATA = !wr_ph ? '0 : first_q ? rom_data : wdata_q;
  assign rom_addr      = ROM_ADDR_W'(sel_q) * ROM_ADDR_W'(NUM_WORDS) + ROM_ADDR_W'(idx_q);
  assign busy          = state_q inside {FETCH, WRITE, VERIFY};
  assign maze_ready    = state_q == DONE;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      first_q   <= 1'b0;
`ifdef MAZE_READBACK_EN
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= FETCH;
          idx_q   <= '0;
          sel_q   <= int'(maze_sel) < NUM_MAZES ? maze_sel : 2'd0;
`ifdef MAZE_READBACK_EN
          err_q   <= 1'b0;
`endif
        end
        FETCH: begin
          state_q <= WRITE;
          first_q <= 1'b1;
        end
        WRITE: begin
          first_q <= 1'b0;
          if (first_q) wdata_q <= rom_data;
          if (!AVM_WAITREQUEST) begin
`ifdef MAZE_READBACK_EN
            state_q <= VERIFY;
`else
            state_q <= adv_d;
            idx_q   <= idx_d;
`endif
          end
        end
`ifdef MAZE_READBACK_EN
        VERIFY: if (rd_pend_q) begin
          rd_pend_q <= 1'b0;
          if (AVM_READDATA != wdata_q) err_q <= 1'b1;
          state_q   <= adv_d;
          idx_q     <= idx_d;
        end else if (!AVM_WAITREQUEST) begin
          rd_pend_q <= 1'b1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_maze_avl_writer.sv
// tb_maze_avl_writer: random ROM contents and stall patterns against a queue/array model of the maze load.
module tb_maze_avl_writer;
  import maze_pkg::*;
  localparam int N = NUM_WORDS;
`ifdef MAZE_READBACK_EN
  localparam int CPW = 4;
`else
  localparam int CPW = 2;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  maze_sel = 2'd0;
  logic [11:0] rom_addr;
  maze_word_t  rom_data;
  logic        AVM_CS, AVM_WRITE;
  logic [9:0]  AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  maze_word_t  AVM_WRITEDATA;
  logic        AVM_WAITREQUEST = 1'b0;
  logic        busy, maze_ready;
`ifdef MAZE_READBACK_EN
  logic        AVM_READ;
  maze_word_t  AVM_READDATA = '0;
  logic        verify_err;
`endif

  maze_avl_writer dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .maze_sel(maze_sel),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .AVM_CS(AVM_CS), .AVM_WRITE(AVM_WRITE), .AVM_ADDR(AVM_ADDR), .AVM_BYTE_EN(AVM_BYTE_EN),
    .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_WAITREQUEST(AVM_WAITREQUEST),
`ifdef MAZE_READBACK_EN
    .AVM_READ(AVM_READ), .AVM_READDATA(AVM_READDATA), .verify_err(verify_err),
`endif
    .busy(busy), .maze_ready(maze_ready)
  );

  initial forever #5 CLK = ~CLK;

  int         n_cmp = 0, n_bad = 0;
  maze_word_t rom [NUM_MAZES*N];
  maze_word_t mem [1024];
  int         log_addr[$];
  bit         hold_v = 0, in_req = 0, wait_mode = 0, rd_pend = 0;
  int         hold_addr, stall_cnt = 0, nreq = 0, rd_addr = 0, corrupt_addr = -1;
  maze_word_t hold_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always_ff @(posedge CLK) rom_data <= (rom_addr < 12'(NUM_MAZES*N)) ? rom[rom_addr] : '0;

  // bus monitor: stability under stall, accepted writes into the slave memory
  initial forever begin
    @(negedge CLK);
    if (!RESET_N) hold_v = 0;
    else if (AVM_CS && AVM_WRITE) begin
      if (hold_v) begin
        chk("hold_addr", 32'(AVM_ADDR), hold_addr);
        chk("hold_data", AVM_WRITEDATA, hold_data);
      end
      hold_v = AVM_WAITREQUEST;
      hold_addr = int'(AVM_ADDR);
      hold_data = AVM_WRITEDATA;
      if (!AVM_WAITREQUEST) begin
        log_addr.push_back(int'(AVM_ADDR));
        mem[AVM_ADDR] = AVM_WRITEDATA;
      end
    end
`ifdef MAZE_READBACK_EN
    if (RESET_N && AVM_CS && AVM_READ && !AVM_WAITREQUEST) begin
      rd_addr = int'(AVM_ADDR);
      rd_pend = 1;
    end
`endif
  end

  // slave: stalls every 7th write for 3 cycles when wait_mode is set
  initial forever begin
    @(posedge CLK); #1;
    if (!RESET_N) begin
      stall_cnt = 0;
      in_req = 0;
      AVM_WAITREQUEST = 0;
    end else begin
      if (!(AVM_CS && AVM_WRITE)) in_req = 0;
      else if (!in_req) begin
        in_req = 1;
        nreq++;
        if (wait_mode && nreq % 7 == 0) stall_cnt = 3;
      end
      AVM_WAITREQUEST = stall_cnt > 0;
      if (stall_cnt > 0) stall_cnt--;
    end
`ifdef MAZE_READBACK_EN
    if (rd_pend) begin
      AVM_READDATA = mem[rd_addr] ^ ((rd_addr == corrupt_addr) ? 32'h1 : 32'h0);
      rd_pend = 0;
    end
`endif
  end

  task automatic chk_quiet(input string t);
    chk({t, "_cs"}, AVM_CS, 0);
    chk({t, "_write"}, AVM_WRITE, 0);
    chk({t, "_addr"}, 32'(AVM_ADDR), 0);
    chk({t, "_be"}, 32'(AVM_BYTE_EN), 0);
    chk({t, "_wdata"}, AVM_WRITEDATA, 0);
    chk({t, "_rom_addr"}, 32'(rom_addr), 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_ready"}, maze_ready, 0);
`ifdef MAZE_READBACK_EN
    chk({t, "_read"}, AVM_READ, 0);
    chk({t, "_verr"}, verify_err, 0);
`endif
  endtask

  // one full load; poke_at >= 0 pulses start with another sel while that address is being written
  task automatic load(input int sel, input int poke_at, input bit wm, input int bad);
    int n, base, exp_lat;
    bit poked = 0;
    base = sel * N;
    for (int k = 0; k < N; k++) mem[k] = ~rom[base + k];
    log_addr.delete();
    nreq = 0;
    wait_mode = wm;
    corrupt_addr = bad;
    start = 1;
    maze_sel = 2'(sel);
    @(posedge CLK); #1;
    start = 0;
    n = 1;
    chk("start_ready_clr", maze_ready, 0);
    chk("start_busy", busy, 1);
    chk("rom_addr_first", 32'(rom_addr), base);
`ifdef MAZE_READBACK_EN
    chk("verr_clr", verify_err, 0);
`endif
    while (!maze_ready && n < 8 * N) begin
      if (!poked && poke_at >= 0 && AVM_CS && AVM_WRITE && int'(AVM_ADDR) == poke_at) begin
        start = 1;
        maze_sel = 2'((sel + 1) % 4);
        poked = 1;
      end
      @(posedge CLK); #1;
      start = 0;
      n++;
    end
    exp_lat = CPW * N + 1 + (wm ? 3 * (N / 7) : 0);
    chk("ready_lat", n, exp_lat);
    chk("busy_done", busy, 0);
    chk("nwrites", log_addr.size(), N);
    for (int k = 0; k < N && k < log_addr.size(); k++) begin
      chk("wr_addr", log_addr[k], k);
      chk("mem", mem[k], rom[base + k]);
    end
`ifdef MAZE_READBACK_EN
    chk("verify_err", verify_err, bad >= 0 && bad < N);
`endif
  endtask

  initial begin
    int n, s;
    for (int a = 0; a < NUM_MAZES * N; a++) rom[a] = a;
    #1 chk_quiet("rst");
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1;
    chk_quiet("post_rst");
    load(0, -1, 0, -1);
    for (int a = 0; a < NUM_MAZES * N; a++) rom[a] = $urandom;
    load(2, -1, 0, -1);
    load(1, -1, 1, 42);
    load(3, 100, 0, -1);
    load(int'($urandom_range(0, 3)), N - 1, 0, -1);
    repeat (3) @(posedge CLK);
    #1;
    chk("ready_hold", maze_ready, 1);
    chk("idle_busy", busy, 0);
    wait_mode = 0;
    start = 1;
    maze_sel = 2'd1;
    @(posedge CLK); #1;
    start = 0;
    log_addr.delete();
    n = 0;
    while (log_addr.size() < 300 && n < 4 * CPW * N) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("mid_reach", log_addr.size() >= 300, 1);
    #2 RESET_N = 0;
    #1 chk_quiet("mid_rst");
    @(posedge CLK); #1;
    chk_quiet("rst_hold");
    RESET_N = 1;
    @(posedge CLK); #1;
    chk_quiet("idle_after");
    s = int'($urandom_range(0, 3));
    load(s, -1, 1'($urandom_range(0, 1)), -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
